// File: rtl/ifft_r2sdf_type2_stage.sv
// Radix-2 single-path delay-feedback stage using the inverse type-2 butterfly.
// Frames are 2*DELAY beats: x0 fills the delay line, x1 yields out0, and the next x0 pushes out1.
module ifft_r2sdf_type2_stage #(
  parameter int unsigned VIRTUAL_DATA_WIDTH = 18,
  parameter int unsigned DELAY              = 4,
  parameter int unsigned SCALE              = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 in_valid,
  input  logic signed [VIRTUAL_DATA_WIDTH-1:0] in_real,
  input  logic signed [VIRTUAL_DATA_WIDTH-1:0] in_imag,
  output logic                                 out_valid,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] out_real,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] out_imag,
  output logic                                 out_first
);

  localparam int unsigned W    = VIRTUAL_DATA_WIDTH;
  localparam int unsigned PtrW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DELAY - 1);

  typedef enum logic [1:0] {StFill, StBfly, StDrain} state_e;

  state_e          state_q;
  logic [PtrW-1:0] ptr_q;
  logic            accept;
  logic            ptr_last;

  logic signed [W-1:0] mem_real [DELAY];
  logic signed [W-1:0] mem_imag [DELAY];
  logic signed [W-1:0] rd_real, rd_imag;

  logic signed [W:0]   sum0_re, sum0_im, sum1_re, sum1_im;
  logic signed [W-1:0] b0_re, b0_im, b1_re, b1_im;

  // Sums carry one guard bit; SCALE picks halving (no overflow) or plain wrap.
  function automatic logic signed [W-1:0] norm(input logic signed [W:0] s);
    if (SCALE != 0) return s[W:1];
    else            return s[W-1:0];
  endfunction

  assign accept   = enable & in_valid;
  assign ptr_last = (ptr_q == PtrLast);
  assign rd_real  = mem_real[ptr_q];
  assign rd_imag  = mem_imag[ptr_q];

  // Delay line holds x0 during BFLY and out1 during DRAIN.
  always_comb begin
    sum0_re = {rd_real[W-1], rd_real} + {in_imag[W-1], in_imag};
    sum0_im = {rd_imag[W-1], rd_imag} - {in_real[W-1], in_real};
    sum1_re = {rd_real[W-1], rd_real} - {in_imag[W-1], in_imag};
    sum1_im = {rd_imag[W-1], rd_imag} + {in_real[W-1], in_real};
    b0_re   = norm(sum0_re);
    b0_im   = norm(sum0_im);
    b1_re   = norm(sum1_re);
    b1_im   = norm(sum1_im);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else if (enable) begin
      if (in_valid) begin
        ptr_q <= ptr_last ? '0 : ptr_q + 1'b1;
        unique case (state_q)
          StFill: begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            if (ptr_last) state_q <= StBfly;
          end
          StBfly: begin
            out_valid <= 1'b1;
            out_first <= (ptr_q == '0);
            out_real  <= b0_re;
            out_imag  <= b0_im;
            if (ptr_last) state_q <= StDrain;
          end
          StDrain: begin
            out_valid <= 1'b1;
            out_first <= 1'b0;
            out_real  <= rd_real;
            out_imag  <= rd_imag;
            if (ptr_last) state_q <= StBfly;
          end
          default: state_q <= StFill;
        endcase
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (state_q == StBfly) begin
        mem_real[ptr_q] <= b1_re;
        mem_imag[ptr_q] <= b1_im;
      end else begin
        mem_real[ptr_q] <= in_real;
        mem_imag[ptr_q] <= in_imag;
      end
    end
  end

endmodule

// File: doc/ifft_r2sdf_type2_stage.md
IFFT_R2SDF_TYPE2_STAGE -- requirements
Module: ifft_r2sdf_type2_stage

Interface
REQ-001 SHALL have parameter VIRTUAL_DATA_WIDTH, default 18, the signed sample width of each real/imag component.
REQ-002 SHALL have parameter DELAY, default 4, the butterfly span D in samples (power of two, >=1).
REQ-003 SHALL have parameter SCALE, default 1: 1 = divide each output by 2 (IFFT per-stage normalization), 0 = no scaling.
REQ-004 SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-005 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  global clock enable; low freezes all state and outputs.
REQ-008 SHALL have port in_valid  input  1  input sample beat qualifier.
REQ-009 SHALL have ports in_real, in_imag  input  VIRTUAL_DATA_WIDTH each, signed input sample.
REQ-010 SHALL have port out_valid  output  1  output sample qualifier, registered.
REQ-011 SHALL have ports out_real, out_imag  output  VIRTUAL_DATA_WIDTH each, signed, registered.
REQ-012 SHALL have port out_first  output  1  high with the first out0 sample (k=0) of each frame.

Function
REQ-013 SHALL accept a beat only when enable=1 and in_valid=1; no other cycle changes any state.
REQ-014 SHALL count accepted beats modulo 2D; beats 0..D-1 of a frame are x0[k], beats D..2D-1 are x1[k], k=0..D-1.
REQ-015 SHALL hold a D-entry delay line (circular buffer, one read/write pointer) advanced once per accepted beat.
REQ-016 SHALL compute the inverse type-2 butterfly: out0 = x0 - j*x1, out1 = x0 + j*x1.
REQ-017 SHALL compute out0 as real = r0 + i1, imag = i0 - r1, and out1 as real = r0 - i1, imag = i0 + r1.
REQ-018 SHALL, with SCALE=1, form sums in VIRTUAL_DATA_WIDTH+1 bits and arithmetic-shift right by 1 (truncate toward -inf), so no overflow occurs.
REQ-019 SHALL, with SCALE=0, truncate sums to VIRTUAL_DATA_WIDTH bits (two's-complement wrap, no saturation).
REQ-020 SHALL implement states FILL, BFLY, DRAIN; reset enters FILL.
REQ-021 SHALL in FILL write x0 into the delay line with no output; after D beats go to BFLY.
REQ-022 SHALL in BFLY read x0[k] from the delay line, output out0[k], and write out1[k] into the same slot; after D beats go to DRAIN.
REQ-023 SHALL in DRAIN output the stored out1[k] and write the new frame's x0[k] into the slot; after D beats go to BFLY.
REQ-024 SHALL assert out_valid exactly one cycle after each accepted beat in BFLY or DRAIN, and never for beats in FILL.
REQ-025 SHALL assert out_first together with out_valid only for the output of BFLY beat k=0.
REQ-026 SHALL hold out_real/out_imag at their last values while out_valid=0.
REQ-027 SHALL give a fixed latency of D+1 cycles from x0[k] accepted to out0[k] presented under continuous input.
REQ-028 SHALL drain the last frame only when upstream supplies D further beats (zeros allowed); those beats start the next frame.
REQ-029 SHALL treat gaps in in_valid at any position as pure stalls: output order and values are unchanged.
REQ-030 SHALL wrap the beat counter from 2D-1 to 0 with no bubble between frames.

Reset
REQ-031 SHALL on rst=1 at a clock edge (regardless of enable) set state FILL, beat count 0, out_valid 0, out_first 0, out_real 0, out_imag 0.
REQ-032 SHALL abandon any partial frame on reset mid-operation; delay-line contents are don't-care and are never output before being rewritten.

Verification
REQ-033 SHALL pass: D=4, SCALE=0, continuous x0=(1,0),(2,0),(3,0),(4,0), x1=(10,0),(20,0),(30,0),(40,0) -> out0 (1,-10),(2,-20),(3,-30),(4,-40) with out_first on first; no output during the first 4 beats.
REQ-034 SHALL pass: the above followed by 4 zero beats -> outputs (1,10),(2,20),(3,30),(4,40), out_first=0.
REQ-035 SHALL pass: SCALE=1, x0[0]=(1,0), x1[0]=(10,0) -> out0[0]=(0,-5), out1[0]=(0,5).
REQ-036 SHALL pass: SCALE=0, x0[0]=(131071,0), x1[0]=(0,1) -> out0[0] real=-131072 (wrap), out1[0] real=131070.
REQ-037 SHALL pass: REQ-033 stimulus with random in_valid gaps and enable low pulses -> identical output sequence, out_valid only one cycle after accepted beats.
REQ-038 SHALL pass: rst asserted at BFLY beat 2 -> next cycle out_valid=0 and outputs 0; the next 4 beats produce no output, then results match REQ-033.
